// File: rtl/wb_burst_master_if.sv
// Bus bundle for wb_burst_master: command, write/read streams,
// completion flags and the Wishbone B4 master signals.
interface wb_burst_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [29:0] cmd_adr;
    logic [7:0]  cmd_len;

    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;

    logic        rd_valid;
    logic [31:0] rd_data;

    logic        done;
    logic        error;

    logic [29:0] wishbone_adr;
    logic [31:0] wishbone_dat_w;
    logic [31:0] wishbone_dat_r;
    logic        wishbone_cyc;
    logic        wishbone_stb;
    logic        wishbone_ack;
    logic        wishbone_we;
    logic [3:0]  wishbone_sel;
    logic [2:0]  wishbone_cti;
    logic [1:0]  wishbone_bte;
    logic        wishbone_err;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_len,
        input  wr_valid, wr_data,
        input  wishbone_dat_r, wishbone_ack, wishbone_err,
        output cmd_ready, wr_ready, rd_valid, rd_data, done, error,
        output wishbone_adr, wishbone_dat_w, wishbone_cyc, wishbone_stb,
        output wishbone_we, wishbone_sel, wishbone_cti, wishbone_bte
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_len,
        output wr_valid, wr_data,
        output wishbone_dat_r, wishbone_ack, wishbone_err,
        input  cmd_ready, wr_ready, rd_valid, rd_data, done, error,
        input  wishbone_adr, wishbone_dat_w, wishbone_cyc, wishbone_stb,
        input  wishbone_we, wishbone_sel, wishbone_cti, wishbone_bte
    );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone B4 burst master: issues one linear incrementing burst per
// command, with ERR and per-beat timeout abort.
module wb_burst_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    wb_burst_master_if.master  bus
);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t      state_q;
    logic [29:0] adr_q;
    logic [31:0] dat_w_q;
    logic        we_q;
    logic        cyc_q;
    logic        stb_q;
    logic [2:0]  cti_q;
    logic [7:0]  rem_q;
    logic [8:0]  unl_q;
    logic        rd_valid_q;
    logic [31:0] rd_data_q;
    logic        done_q;
    logic        error_q;
    logic [31:0] tmo_q;

    logic        in_burst;
    logic        beat_ack;
    logic        beat_err;
    logic        tmo_hit;
    logic        wr_ready_c;
    logic        load;
    logic [29:0] adr_d;
    logic [7:0]  rem_d;

    // Beat qualification, timeout detection and write-stream handshake.
    always_comb begin
        in_burst   = (state_q == BURST);
        beat_err   = in_burst && stb_q && bus.wishbone_err;
        beat_ack   = in_burst && stb_q && bus.wishbone_ack && !bus.wishbone_err;
        tmo_hit    = (TIMEOUT != 0) && in_burst && stb_q && !bus.wishbone_ack &&
                     !bus.wishbone_err && (tmo_q == TIMEOUT - 32'd1);
        wr_ready_c = in_burst && we_q && (!stb_q || bus.wishbone_ack) && (unl_q != '0);
        load       = wr_ready_c && bus.wr_valid;
        adr_d      = adr_q + 30'd1;
        rem_d      = rem_q - 8'd1;
    end

    // Burst FSM with all bus/stream outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            adr_q      <= '0;
            dat_w_q    <= '0;
            we_q       <= 1'b0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            cti_q      <= '0;
            rem_q      <= '0;
            unl_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            tmo_q      <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        state_q <= BURST;
                        adr_q   <= bus.cmd_adr;
                        we_q    <= bus.cmd_we;
                        rem_q   <= bus.cmd_len;
                        unl_q   <= {1'b0, bus.cmd_len} + 9'd1;
                        cyc_q   <= 1'b1;
                        stb_q   <= !bus.cmd_we;
                        cti_q   <= (bus.cmd_len == '0) ? 3'b111 : 3'b010;
                        tmo_q   <= '0;
                    end
                end
                BURST: begin
                    if (beat_err || tmo_hit) begin
                        state_q <= IDLE;
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        cti_q   <= '0;
                        done_q  <= 1'b1;
                        error_q <= 1'b1;
                        tmo_q   <= '0;
                    end else begin
                        tmo_q <= (stb_q && !bus.wishbone_ack) ? tmo_q + 32'd1 : '0;
                        if (load) begin
                            dat_w_q <= bus.wr_data;
                            unl_q   <= unl_q - 9'd1;
                        end
                        // Writes strobe only while a loaded word is pending.
                        if (we_q) begin
                            if (load)
                                stb_q <= 1'b1;
                            else if (beat_ack)
                                stb_q <= 1'b0;
                        end
                        if (beat_ack) begin
                            adr_q <= adr_d;
                            rem_q <= rem_d;
                            cti_q <= (rem_d == '0) ? 3'b111 : 3'b010;
                            if (!we_q) begin
                                rd_valid_q <= 1'b1;
                                rd_data_q  <= bus.wishbone_dat_r;
                            end
                            // Last beat overrides the stb/cti updates above.
                            if (rem_q == '0) begin
                                state_q <= IDLE;
                                cyc_q   <= 1'b0;
                                stb_q   <= 1'b0;
                                cti_q   <= '0;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready      = (state_q == IDLE);
    assign bus.wr_ready       = wr_ready_c;
    assign bus.rd_valid       = rd_valid_q;
    assign bus.rd_data        = rd_data_q;
    assign bus.done           = done_q;
    assign bus.error          = error_q;
    assign bus.wishbone_adr   = adr_q;
    assign bus.wishbone_dat_w = dat_w_q;
    assign bus.wishbone_cyc   = cyc_q;
    assign bus.wishbone_stb   = stb_q;
    assign bus.wishbone_we    = we_q;
    assign bus.wishbone_sel   = 4'hF;
    assign bus.wishbone_cti   = cti_q;
    assign bus.wishbone_bte   = 2'b00;

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed self-checking bench for wb_burst_master with a small
// Wishbone slave model and write-stream source.
module tb_wb_burst_master;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_burst_master_if bus ();

    wb_burst_master #(.TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // slave: 0 zero-wait, 1 one wait state, 2 ERR(+ACK) on beat 3, 3 never answers
    int          s_mode;
    logic        ack_q;
    int          s_beats;
    int          wr_idx;
    int          wr_n;
    logic        wr_on;
    int          stall_left;
    logic [31:0] wr_words [0:7];

    assign bus.wishbone_ack   = bus.wishbone_stb &&
                                ((s_mode == 0) || (s_mode == 2) || (s_mode == 1 && ack_q));
    assign bus.wishbone_err   = bus.wishbone_stb && (s_mode == 2) && (s_beats == 2);
    assign bus.wishbone_dat_r = {2'b00, bus.wishbone_adr} ^ 32'hA5A5_0000;
    assign bus.wr_valid       = wr_on && (wr_idx < wr_n) && !(wr_idx == 2 && stall_left != 0);
    assign bus.wr_data        = wr_words[wr_idx[2:0]];

    logic [29:0] b_adr [0:31];
    logic [2:0]  b_cti [0:31];
    logic [31:0] b_dat [0:31];
    logic [31:0] r_dat [0:31];
    int beat_n, rd_n, done_n, err_n, done_err_n, stb_n, stall_n, stall_bad, cyc_at_done;
    logic [29:0] stall_adr_exp;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        beat_n = 0; rd_n = 0; done_n = 0; err_n = 0; done_err_n = 0;
        stb_n = 0; stall_n = 0; stall_bad = 0; cyc_at_done = 0;
        s_beats = 0; ack_q = 1'b0; wr_idx = 0; stall_left = 0;
    endtask

    // Sample at negedge, then advance to just after the next rising edge.
    task automatic step();
        logic take, ackq_n, beat, dec;
        @(negedge clk);
        take   = bus.wr_valid && bus.wr_ready;
        ackq_n = bus.wishbone_stb && !bus.wishbone_ack;
        beat   = bus.wishbone_cyc && bus.wishbone_stb && bus.wishbone_ack && !bus.wishbone_err;
        dec    = (wr_idx == 2) && (s_beats >= 2) && (stall_left > 0);
        if (beat && beat_n < 32) begin
            b_adr[beat_n] = bus.wishbone_adr;
            b_cti[beat_n] = bus.wishbone_cti;
            b_dat[beat_n] = bus.wishbone_dat_w;
        end
        if (beat) beat_n++;
        if (bus.wishbone_stb) stb_n++;
        if (bus.wishbone_cyc && !bus.wishbone_stb && s_beats >= 1) begin
            stall_n++;
            if (bus.wishbone_adr != stall_adr_exp) stall_bad++;
        end
        if (bus.rd_valid && rd_n < 32) r_dat[rd_n] = bus.rd_data;
        if (bus.rd_valid) rd_n++;
        if (bus.done) begin
            done_n++;
            if (bus.wishbone_cyc) cyc_at_done = 1;
            if (bus.error) done_err_n++;
        end
        if (bus.error) err_n++;
        @(posedge clk);
        #1;
        if (take) wr_idx++;
        ack_q = ackq_n;
        if (beat) s_beats++;
        if (dec) stall_left--;
    endtask

    task automatic issue(input logic we, input logic [29:0] a, input logic [7:0] len);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = we;
        bus.cmd_adr   = a;
        bus.cmd_len   = len;
        chk("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (done_n == 0 && k < 200) begin
            step();
            k++;
        end
        chk("done_seen", 32'(done_n != 0), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_adr = '0; bus.cmd_len = '0;
        s_mode = 0; wr_on = 1'b0; wr_n = 0; stall_adr_exp = '0;
        for (int i = 0; i < 8; i++) wr_words[i] = '0;
        clear_logs();
        @(posedge clk); #1;
        repeat (3) step();

        // reset state
        chk("rst_cyc",   32'(bus.wishbone_cyc),   32'd0);
        chk("rst_stb",   32'(bus.wishbone_stb),   32'd0);
        chk("rst_we",    32'(bus.wishbone_we),    32'd0);
        chk("rst_adr",   32'(bus.wishbone_adr),   32'd0);
        chk("rst_datw",  bus.wishbone_dat_w,      32'd0);
        chk("rst_cti",   32'(bus.wishbone_cti),   32'd0);
        chk("rst_done",  32'(bus.done),           32'd0);
        chk("rst_error", 32'(bus.error),          32'd0);
        chk("rst_rdv",   32'(bus.rd_valid),       32'd0);
        chk("rst_wrrdy", 32'(bus.wr_ready),       32'd0);
        chk("rst_sel",   32'(bus.wishbone_sel),   32'hF);
        chk("rst_bte",   32'(bus.wishbone_bte),   32'd0);
        reset = 1'b0;
        step();

        // 4-beat write, zero-wait slave
        clear_logs();
        s_mode = 0;
        for (int i = 0; i < 4; i++) wr_words[i] = 32'(i + 1);
        wr_n = 4; wr_on = 1'b1;
        issue(1'b1, 30'h10, 8'd3);
        wait_done();
        wr_on = 1'b0;
        chk("w1_beats", 32'(beat_n), 32'd4);
        chk("w1_adr0", 32'(b_adr[0]), 32'h10);
        chk("w1_adr1", 32'(b_adr[1]), 32'h11);
        chk("w1_adr2", 32'(b_adr[2]), 32'h12);
        chk("w1_adr3", 32'(b_adr[3]), 32'h13);
        chk("w1_dat0", b_dat[0], 32'd1);
        chk("w1_dat3", b_dat[3], 32'd4);
        chk("w1_cti0", 32'(b_cti[0]), 32'd2);
        chk("w1_cti2", 32'(b_cti[2]), 32'd2);
        chk("w1_cti3", 32'(b_cti[3]), 32'd7);
        chk("w1_stb_cycles", 32'(stb_n), 32'd4);
        chk("w1_done_cnt", 32'(done_n), 32'd1);
        chk("w1_err_cnt", 32'(err_n), 32'd0);
        chk("w1_cyc_at_done", 32'(cyc_at_done), 32'd0);
        chk("w1_words_used", 32'(wr_idx), 32'd4);
        step();
        chk("w1_cmd_ready_after", 32'(bus.cmd_ready), 32'd1);

        // 8-beat read with one wait state per beat; stray command mid-burst
        clear_logs();
        s_mode = 1;
        issue(1'b0, 30'h100, 8'd7);
        repeat (3) step();
        bus.cmd_valid = 1'b1; bus.cmd_we = 1'b1; bus.cmd_adr = 30'h999; bus.cmd_len = 8'd0;
        step();
        bus.cmd_valid = 1'b0;
        wait_done();
        chk("r8_rdv_cnt", 32'(rd_n), 32'd8);
        chk("r8_beats", 32'(beat_n), 32'd8);
        chk("r8_dat0", r_dat[0], 32'hA5A5_0100);
        chk("r8_dat3", r_dat[3], 32'hA5A5_0103);
        chk("r8_dat7", r_dat[7], 32'hA5A5_0107);
        chk("r8_adr5", 32'(b_adr[5]), 32'h105);
        chk("r8_cti6", 32'(b_cti[6]), 32'd2);
        chk("r8_cti7", 32'(b_cti[7]), 32'd7);
        chk("r8_stb_cycles", 32'(stb_n), 32'd16);
        chk("r8_err_cnt", 32'(err_n), 32'd0);

        // single beat at top of address space
        clear_logs();
        s_mode = 0;
        issue(1'b0, 30'h3FFF_FFFF, 8'd0);
        chk("r1_cti_live", 32'(bus.wishbone_cti), 32'd7);
        chk("r1_bte_live", 32'(bus.wishbone_bte), 32'd0);
        chk("r1_cyc_live", 32'(bus.wishbone_cyc), 32'd1);
        wait_done();
        chk("r1_beats", 32'(beat_n), 32'd1);
        chk("r1_adr0", 32'(b_adr[0]), 32'h3FFF_FFFF);
        chk("r1_dat0", r_dat[0], 32'h9A5A_FFFF);

        // two beats wrapping the address
        clear_logs();
        issue(1'b0, 30'h3FFF_FFFF, 8'd1);
        wait_done();
        chk("rw_beats", 32'(beat_n), 32'd2);
        chk("rw_adr0", 32'(b_adr[0]), 32'h3FFF_FFFF);
        chk("rw_adr1", 32'(b_adr[1]), 32'h0);
        chk("rw_cti0", 32'(b_cti[0]), 32'd2);
        chk("rw_cti1", 32'(b_cti[1]), 32'd7);
        chk("rw_dat1", r_dat[1], 32'hA5A5_0000);

        // write with stream gap after beat 2 (3 idle source cycles + 1 load cycle)
        clear_logs();
        s_mode = 0;
        for (int i = 0; i < 4; i++) wr_words[i] = 32'h11 + 32'(i);
        wr_n = 4; stall_left = 3; stall_adr_exp = 30'h22; wr_on = 1'b1;
        issue(1'b1, 30'h20, 8'd3);
        wait_done();
        wr_on = 1'b0;
        chk("ws_beats", 32'(beat_n), 32'd4);
        chk("ws_adr3", 32'(b_adr[3]), 32'h23);
        chk("ws_dat2", b_dat[2], 32'h13);
        chk("ws_dat3", b_dat[3], 32'h14);
        chk("ws_cti3", 32'(b_cti[3]), 32'd7);
        chk("ws_stall_cycles", 32'(stall_n), 32'd4);
        chk("ws_stall_adr_bad", 32'(stall_bad), 32'd0);
        chk("ws_stb_cycles", 32'(stb_n), 32'd4);

        // ERR together with ACK on beat 3 of an 8-beat read
        clear_logs();
        s_mode = 2;
        issue(1'b0, 30'h200, 8'd7);
        wait_done();
        chk("er_rdv_cnt", 32'(rd_n), 32'd2);
        chk("er_dat1", r_dat[1], 32'hA5A5_0201);
        chk("er_beats", 32'(beat_n), 32'd2);
        chk("er_err_cnt", 32'(err_n), 32'd1);
        chk("er_done_with_err", 32'(done_err_n), 32'd1);
        chk("er_cyc_at_done", 32'(cyc_at_done), 32'd0);

        // silent slave: abort after 4 strobe cycles
        clear_logs();
        s_mode = 3;
        issue(1'b0, 30'h300, 8'd3);
        wait_done();
        chk("to_stb_cycles", 32'(stb_n), 32'd4);
        chk("to_beats", 32'(beat_n), 32'd0);
        chk("to_rdv_cnt", 32'(rd_n), 32'd0);
        chk("to_err_cnt", 32'(err_n), 32'd1);
        chk("to_done_with_err", 32'(done_err_n), 32'd1);

        // reset in the middle of a 16-beat read
        clear_logs();
        s_mode = 0;
        issue(1'b0, 30'h400, 8'd15);
        repeat (5) step();
        reset = 1'b1;
        step();
        chk("mr_cyc", 32'(bus.wishbone_cyc), 32'd0);
        chk("mr_stb", 32'(bus.wishbone_stb), 32'd0);
        chk("mr_done", 32'(bus.done), 32'd0);
        chk("mr_rdv", 32'(bus.rd_valid), 32'd0);
        chk("mr_adr", 32'(bus.wishbone_adr), 32'd0);
        chk("mr_beats_before", 32'(beat_n), 32'd6);
        reset = 1'b0;
        repeat (3) step();
        chk("mr_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("mr_done_cnt", 32'(done_n), 32'd0);
        chk("mr_cyc_after", 32'(bus.wishbone_cyc), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
